// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave responder.
// Holds the FSM state encoding, ACK/NACK bus levels and the R/W bit position.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } state_t;

  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;
  localparam int   RW_BIT = 0;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers on SCL/SDA plus a history flop for edge and START/STOP detection.
// Detection outputs are combinational from the flops; no backpressure.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_d;
  logic       sda_d;
  logic       scl_s;

  // Reset to the idle-bus level so leaving reset never looks like an edge on SDA.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda};
      scl_d  <= scl_ff[1];
      sda_d  <= sda_ff[1];
    end
  end

  assign scl_s    = scl_ff[1];
  assign sda_s    = sda_ff[1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  // Requiring SCL high on both samples means an SCL edge always wins over an SDA edge.
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_core.sv
// Addressable I2C slave: address match, pointer byte, auto-incrementing register bank.
// Bus is not stretched; local read port has 1-cycle latency; write strobe is a 1-cycle pulse.
module i2c_slave_core
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h10,
  parameter int         MEM_DEPTH  = 16,
  localparam int        AW         = $clog2(MEM_DEPTH)
) (
  input  logic          i2c_core_clock_i,
  input  logic          i2c_core_reset_i,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe_o,
  input  logic [AW-1:0] reg_raddr_i,
  output logic [7:0]    reg_rdata_o,
  output logic          wr_valid_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [7:0]    wr_data_o,
  output logic          busy_o
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk       (i2c_core_clock_i),
    .rst       (i2c_core_reset_i),
    .scl       (scl_i),
    .sda       (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [6:0]    rx_sh;
  logic [7:0]    tx_byte;
  logic [AW-1:0] ptr;
  logic          rw;
  logic          slot_seen;
  logic [7:0]    mem [MEM_DEPTH];
  logic [7:0]    byte_in;

  assign byte_in = {rx_sh, sda_s};

  always_ff @(posedge i2c_core_clock_i) begin
    if (i2c_core_reset_i) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      rx_sh       <= 7'd0;
      tx_byte     <= 8'h00;
      ptr         <= '0;
      rw          <= 1'b0;
      slot_seen   <= 1'b0;
      sda_oe_o    <= 1'b0;
      busy_o      <= 1'b0;
      wr_valid_o  <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= 8'h00;
      reg_rdata_o <= 8'h00;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      wr_valid_o  <= 1'b0;
      reg_rdata_o <= mem[reg_raddr_i];
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        slot_seen <= 1'b0;
        sda_oe_o  <= 1'b0;
        busy_o    <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WR_DATA: begin
            if (scl_rise) begin
              rx_sh   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == ADDR) begin
                  if (byte_in[7:1] == SLAVE_ADDR) begin
                    state  <= ADDR_ACK;
                    rw     <= byte_in[RW_BIT];
                    busy_o <= 1'b1;
                  end else begin
                    state <= IDLE;
                  end
                end else if (state == PTR) begin
                  ptr   <= byte_in[AW-1:0];
                  state <= PTR_ACK;
                end else begin
                  mem[ptr]   <= byte_in;
                  wr_valid_o <= 1'b1;
                  wr_addr_o  <= ptr;
                  wr_data_o  <= byte_in;
                  ptr        <= ptr + AW'(1);
                  state      <= WR_ACK;
                end
              end
            end
          end
          // First fall opens the ACK slot, the rise marks it seen, the next fall closes it.
          ADDR_ACK, PTR_ACK, WR_ACK: begin
            if (scl_rise) begin
              slot_seen <= 1'b1;
            end else if (scl_fall) begin
              if (!slot_seen) begin
                sda_oe_o <= ~ACK;
              end else begin
                slot_seen <= 1'b0;
                bit_cnt   <= 3'd0;
                sda_oe_o  <= 1'b0;
                if (state == ADDR_ACK && rw) begin
                  tx_byte  <= mem[ptr];
                  ptr      <= ptr + AW'(1);
                  sda_oe_o <= ~mem[ptr][7];
                  state    <= RD_DATA;
                end else if (state == ADDR_ACK) begin
                  state <= PTR;
                end else begin
                  state <= WR_DATA;
                end
              end
            end
          end
          RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= RD_ACK;
            end else if (scl_fall) begin
              sda_oe_o <= ~tx_byte[3'd7 - bit_cnt];
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_s == NACK) begin
                state  <= IDLE;
                busy_o <= 1'b0;
              end else begin
                slot_seen <= 1'b1;
              end
            end else if (scl_fall) begin
              if (!slot_seen) begin
                sda_oe_o <= 1'b0;
              end else begin
                slot_seen <= 1'b0;
                bit_cnt   <= 3'd0;
                tx_byte   <= mem[ptr];
                ptr       <= ptr + AW'(1);
                sda_oe_o  <= ~mem[ptr][7];
                state     <= RD_DATA;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Directed bench for i2c_slave_core: a bit-banged I2C master on an open-drain SDA line,
// with hand-computed expectations for writes, reads, wrap, mismatch, STOP and reset.
module tb_i2c_slave_core;
  import i2c_slave_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [3:0] raddr = 4'd0;
  logic [7:0] rdata;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] wq_a [$];
  logic [7:0] wq_d [$];
  bit         oe_seen = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_core dut (
    .i2c_core_clock_i (clk),
    .i2c_core_reset_i (rst),
    .scl_i            (scl_m),
    .sda_i            (sda_line),
    .sda_oe_o         (sda_oe),
    .reg_raddr_i      (raddr),
    .reg_rdata_o      (rdata),
    .wr_valid_o       (wr_valid),
    .wr_addr_o        (wr_addr),
    .wr_data_o        (wr_data),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && wr_valid) begin
      wq_a.push_back(wr_addr);
      wq_d.push_back(wr_data);
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clks(4);
    scl_m = 1'b1; wait_clks(8);
    sda_m = 1'b0; wait_clks(8);
    scl_m = 1'b0; wait_clks(4);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clks(4);
    scl_m = 1'b1; wait_clks(8);
    sda_m = 1'b1; wait_clks(8);
  endtask

  task automatic clk_bit(input logic b, output logic r);
    sda_m = b;    wait_clks(4);
    scl_m = 1'b1; wait_clks(4);
    r = sda_line; wait_clks(4);
    scl_m = 1'b0; wait_clks(4);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      d[i] = r;
    end
    clk_bit(ack_bit, r);
  endtask

  task automatic rd_local(input logic [3:0] a, output logic [7:0] d);
    raddr = a;
    wait_clks(2);
    d = rdata;
  endtask

  initial begin
    logic       ack;
    logic       r;
    logic [7:0] d;
    logic [7:0] wb [5];
    int         nwr;

    wb = '{8'h55, 8'h51, 8'h35, 8'h7D, 8'h77};

    wait_clks(3);
    chk("rst_sda_oe",   32'(sda_oe),   32'h0);
    chk("rst_busy",     32'(busy),     32'h0);
    chk("rst_wr_valid", 32'(wr_valid), 32'h0);
    chk("rst_wr_addr",  32'(wr_addr),  32'h0);
    chk("rst_wr_data",  32'(wr_data),  32'h0);
    chk("rst_rdata",    32'(rdata),    32'h0);
    rst = 1'b0;
    wait_clks(4);

    // Write burst from pointer 0
    bus_start();
    send_byte(8'h20, ack); chk("wb_ack_addr", 32'(ack), 32'(ACK));
    chk("wb_busy_on", 32'(busy), 32'h1);
    send_byte(8'h00, ack); chk("wb_ack_ptr", 32'(ack), 32'(ACK));
    for (int i = 0; i < 5; i++) begin
      send_byte(wb[i], ack);
      chk($sformatf("wb_ack_d%0d", i), 32'(ack), 32'(ACK));
    end
    bus_stop();
    chk("wb_busy_off", 32'(busy), 32'h0);
    chk("wb_pulses", 32'(wq_a.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("wb_waddr%0d", i), 32'(wq_a[i]), 32'(i));
      chk($sformatf("wb_wdata%0d", i), 32'(wq_d[i]), 32'(wb[i]));
      rd_local(4'(i), d);
      chk($sformatf("wb_mem%0d", i), 32'(d), 32'(wb[i]));
    end

    // Pointer write, repeated START, read back 5 bytes
    bus_start();
    send_byte(8'h20, ack);
    send_byte(8'h00, ack);
    bus_start();
    send_byte(8'h21, ack); chk("rd_ack_addr", 32'(ack), 32'(ACK));
    for (int i = 0; i < 5; i++) begin
      read_byte((i == 4) ? NACK : ACK, d);
      chk($sformatf("rd_byte%0d", i), 32'(d), 32'(wb[i]));
    end
    wait_clks(2);
    chk("rd_busy_after_nack", 32'(busy), 32'h0);
    bus_stop();

    // Address mismatch is ignored
    oe_seen = 1'b0;
    nwr = wq_a.size();
    bus_start();
    send_byte(8'h22, ack); chk("mm_ack_addr", 32'(ack), 32'(NACK));
    send_byte(8'hFF, ack); chk("mm_ack_data", 32'(ack), 32'(NACK));
    chk("mm_busy", 32'(busy), 32'h0);
    bus_stop();
    chk("mm_oe_seen", 32'(oe_seen), 32'h0);
    chk("mm_no_write", 32'(wq_a.size()), 32'(nwr));

    // Pointer wrap on write, then upper pointer bits ignored on read
    nwr = wq_a.size();
    bus_start();
    send_byte(8'h20, ack);
    send_byte(8'h0F, ack);
    send_byte(8'hAA, ack);
    send_byte(8'hBB, ack);
    bus_stop();
    chk("wr_pulses", 32'(wq_a.size()), 32'(nwr + 2));
    chk("wr_waddr_a", 32'(wq_a[nwr]),     32'd15);
    chk("wr_wdata_a", 32'(wq_d[nwr]),     32'hAA);
    chk("wr_waddr_b", 32'(wq_a[nwr + 1]), 32'd0);
    chk("wr_wdata_b", 32'(wq_d[nwr + 1]), 32'hBB);
    rd_local(4'd15, d); chk("wr_mem15", 32'(d), 32'hAA);
    rd_local(4'd0,  d); chk("wr_mem0",  32'(d), 32'hBB);
    bus_start();
    send_byte(8'h20, ack);
    send_byte(8'h1F, ack); chk("wr_ack_ptr1f", 32'(ack), 32'(ACK));
    bus_start();
    send_byte(8'h21, ack);
    read_byte(NACK, d); chk("wr_read_1f", 32'(d), 32'hAA);
    bus_stop();

    // STOP after 3 data bits: no commit
    nwr = wq_a.size();
    bus_start();
    send_byte(8'h20, ack);
    send_byte(8'h00, ack);
    clk_bit(1'b1, r);
    clk_bit(1'b0, r);
    clk_bit(1'b1, r);
    bus_stop();
    wait_clks(4);
    chk("sp_no_write", 32'(wq_a.size()), 32'(nwr));
    chk("sp_busy",     32'(busy),        32'h0);
    chk("sp_sda_oe",   32'(sda_oe),      32'h0);
    chk("sp_state",    32'(dut.state),   32'(IDLE));
    rd_local(4'd0, d); chk("sp_mem0", 32'(d), 32'hBB);

    // Reset while driving a 0 data bit (mem[1] = 51, MSB 0)
    bus_start();
    send_byte(8'h20, ack);
    send_byte(8'h01, ack);
    bus_start();
    send_byte(8'h21, ack);
    wait_clks(4);
    chk("rs_driving_low", 32'(sda_oe), 32'h1);
    rst = 1'b1;
    wait_clks(1);
    chk("rs_sda_released", 32'(sda_oe), 32'h0);
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);
    chk("rs_ptr", 32'(dut.ptr), 32'h0);
    for (int i = 0; i < 16; i++) begin
      rd_local(4'(i), d);
      chk($sformatf("rs_mem%0d", i), 32'(d), 32'h0);
    end
    bus_stop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
